// File: rtl/wb_spi_slave_pkg.sv
// Shared definitions for the Wishbone SPI responder: register indices,
// STATUS bit layout and FSM state encoding.
package wb_spi_slave_pkg;

  // Register index taken from wb_adr_i[5:2]
  localparam logic [3:0] REG_DATA   = 4'd0;
  localparam logic [3:0] REG_STATUS = 4'd1;
  localparam logic [3:0] REG_IRQEN  = 4'd2;

  // STATUS bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_RX_FULL = 1;
  localparam int STAT_TX_FULL = 2;
  localparam int STAT_OVR     = 3;
  localparam int STAT_UDR     = 4;

  // Frame FSM: IDLE while chip select is inactive, SEL while a frame runs
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEL  = 1'b1
  } spi_state_t;

  // Packed so that the first member lands on the highest bit (udr = bit 4)
  typedef struct packed {
    logic udr;
    logic ovr;
    logic tx_full;
    logic rx_full;
    logic busy;
  } status_t;

  // Zero-extends the STATUS flags into a bus word
  function automatic logic [31:0] status_word(input status_t s);
    return {27'b0, s};
  endfunction

endpackage

// File: rtl/wb_spi_slave_sync_edge.sv
// N-stage synchroniser for an asynchronous pin with single-cycle rise/fall
// pulses derived from the synchronised level.
module wb_spi_slave_sync_edge #(
  parameter int   STAGES    = 2,     // must be >= 2
  parameter logic RESET_VAL = 1'b0   // pin's inactive level
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the pin through the synchroniser and remember the previous level
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, as real hardware does.
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/wb_spi_slave.sv
// SPI responder (mode 0, MSB first, 8-bit frames) with a Wishbone register
// interface. Optional build macro: WB_SPI_SLAVE_IRQ_EN enables the irq_en
// register (index 2) and the level interrupt output; without it irq is 0.
module wb_spi_slave
  import wb_spi_slave_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq
);

  // ---------------------------------------------------------------------
  // Pin synchronisation
  // ---------------------------------------------------------------------
  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_bit;

  wb_spi_slave_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk   (clk),
    .reset (reset),
    .din   (spi_sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  wb_spi_slave_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .din   (spi_cs_n),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // MOSI only needs its level; it shares the sck pipeline depth so a sampled
  // bit lines up with the sck rise pulse
  always_ff @(posedge clk) begin
    if (reset) mosi_sync_q <= '0;
    else       mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
  end

  assign mosi_bit = mosi_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Wishbone decode
  // ---------------------------------------------------------------------
  logic       ack_q;
  logic       bus_req, rd_en, wr_en;
  logic [3:0] reg_idx;
  logic       wr_tx, rd_rx, wr_status;

  assign bus_req   = wb_cyc_i & wb_stb_i;
  assign rd_en     = bus_req & ~wb_we_i & ~ack_q;
  assign wr_en     = bus_req &  wb_we_i & ~ack_q;
  assign reg_idx   = wb_adr_i[5:2];
  assign wr_tx     = wr_en && (reg_idx == REG_DATA);
  assign rd_rx     = rd_en && (reg_idx == REG_DATA);
  assign wr_status = wr_en && (reg_idx == REG_STATUS);
  assign wb_ack_o  = bus_req & ack_q;

  // Byte lanes and unused address/data bits have no function here
  logic unused_bits;
  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i[31:8]};

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  spi_state_t state, state_next;
  logic       frame_start, frame_abort, bit_sample, bit_shift;
  logic       byte_done, tx_load;
  logic [2:0] bitcnt;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state and per-cycle frame events
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_next  = state;
    frame_start = 1'b0;
    frame_abort = 1'b0;
    bit_sample  = 1'b0;
    bit_shift   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cs_fall) begin
          state_next  = ST_SEL;
          frame_start = 1'b1;
        end
      end
      ST_SEL: begin
        if (cs_rise) begin
          state_next  = ST_IDLE;
          frame_abort = 1'b1;
        end else begin
          bit_sample = sck_rise;
          bit_shift  = sck_fall;
        end
      end
    endcase
  end

  // The 8th falling edge completes a byte and reloads the next TX byte
  assign byte_done = bit_shift && (bitcnt == 3'd7);
  assign tx_load   = frame_start | byte_done;

  // ---------------------------------------------------------------------
  // Shift path and holding registers
  // ---------------------------------------------------------------------
  logic [7:0] shift_q, tx_hold, rx_hold, load_byte, rx_byte;
  logic       in_bit, tx_full, rx_full, ovr, udr;

  assign load_byte = tx_full ? tx_hold : IDLE_BYTE;
  assign rx_byte   = {shift_q[6:0], in_bit};

  // Bit counter, shifter, TX/RX holding registers and sticky flags
  always_ff @(posedge clk) begin
    // NOTE: every flag and holding register is cleared by reset; software
    // reads RXDATA/STATUS right after reset and must see defined values.
    if (reset) begin
      bitcnt  <= 3'd0;
      in_bit  <= 1'b0;
      shift_q <= IDLE_BYTE;
      tx_hold <= 8'h00;
      tx_full <= 1'b0;
      rx_hold <= 8'h00;
      rx_full <= 1'b0;
      ovr     <= 1'b0;
      udr     <= 1'b0;
    end else begin
      if (frame_start || frame_abort) bitcnt <= 3'd0;
      else if (bit_shift)             bitcnt <= bitcnt + 3'd1;

      if (bit_sample) in_bit <= mosi_bit;

      if (tx_load)        shift_q <= load_byte;
      else if (bit_shift) shift_q <= rx_byte;

      // A CPU write coinciding with a load still leaves a byte pending: the
      // load consumed the old value, the new one waits for the next frame.
      if (wr_tx) begin
        tx_hold <= wb_dat_i[7:0];
        tx_full <= 1'b1;
      end else if (tx_load && tx_full) begin
        tx_full <= 1'b0;
      end

      if (tx_load && !tx_full)           udr <= 1'b1;
      else if (wr_status && wb_dat_i[4]) udr <= 1'b0;

      if (byte_done && rx_full)          ovr <= 1'b1;
      else if (wr_status && wb_dat_i[3]) ovr <= 1'b0;

      if (byte_done) begin
        rx_hold <= rx_byte;
        rx_full <= 1'b1;
      end else if (rd_rx) begin
        rx_full <= 1'b0;
      end
    end
  end

  assign spi_miso_oe = (state == ST_SEL);
  assign spi_miso    = (state == ST_SEL) ? shift_q[7] : 1'b0;

  // ---------------------------------------------------------------------
  // Interrupt enable (optional)
  // ---------------------------------------------------------------------
`ifdef WB_SPI_SLAVE_IRQ_EN
  logic [1:0] irq_en;
  logic       wr_irqen;

  assign wr_irqen = wr_en && (reg_idx == REG_IRQEN);

  // irq_en[0] selects rx_full, irq_en[1] selects tx holding register empty
  always_ff @(posedge clk) begin
    if (reset)         irq_en <= 2'b00;
    else if (wr_irqen) irq_en <= wb_dat_i[1:0];
  end

  assign irq = (irq_en[0] & rx_full) | (irq_en[1] & ~tx_full);
`else
  assign irq = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  status_t     status;
  logic [31:0] rd_data;

  assign status = '{udr: udr, ovr: ovr, tx_full: tx_full, rx_full: rx_full,
                    busy: (state == ST_SEL)};

  // Register read multiplexer; unmapped indices read as zero
  always_comb begin
    rd_data = '0;
    case (reg_idx)
      REG_DATA:   rd_data = {24'b0, rx_hold};
      REG_STATUS: rd_data = status_word(status);
`ifdef WB_SPI_SLAVE_IRQ_EN
      REG_IRQEN:  rd_data = {30'b0, irq_en};
`endif
      default:    rd_data = '0;
    endcase
  end

  // One wait state: ack follows the request by a cycle; read data is latched
  // on the accepting cycle so it is stable while ack is high
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q    <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      ack_q <= bus_req;
      if (rd_en) wb_dat_o <= rd_data;
    end
  end

endmodule

// File: tb/tb_wb_spi_slave.sv
// Self-checking bench for wb_spi_slave: an SPI master and a Wishbone CPU
// drive traffic, a reference model predicts read data and MISO bits, and
// monitors compare against queued expectations.
module tb_wb_spi_slave;

  localparam int         HALF = 6;        // clk cycles per sck half period
  localparam logic [7:0] IDLE = 8'hC3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i = 4'hF;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic        wb_ack_o;
  logic        spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe, irq;

  wb_spi_slave #(.SYNC_STAGES(2), .IDLE_BYTE(IDLE)) dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard queues
  logic [31:0] exp_data[$];
  string       exp_name[$];
  logic        exp_miso[$];
  logic [7:0]  mosi_bytes[$];

  // Reference model state
  logic       m_tx_full = 1'b0, m_rx_full = 1'b0, m_ovr = 1'b0, m_udr = 1'b0;
  logic [7:0] m_tx_hold = 8'h00, m_rx_hold = 8'h00;
`ifdef WB_SPI_SLAVE_IRQ_EN
  logic [1:0] m_irq_en = 2'b00;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_status(input logic busy);
    return {27'b0, m_udr, m_ovr, m_tx_full, m_rx_full, busy};
  endfunction

  // Byte the responder will shift out next; consumes the pending TX byte
  function automatic logic [7:0] m_load();
    logic [7:0] b;
    if (m_tx_full) begin
      b = m_tx_hold;
      m_tx_full = 1'b0;
    end else begin
      b = IDLE;
      m_udr = 1'b1;
    end
    return b;
  endfunction

  function automatic void m_rx_byte(input logic [7:0] b);
    if (m_rx_full) m_ovr = 1'b1;
    m_rx_hold = b;
    m_rx_full = 1'b1;
  endfunction

  function automatic void m_reset();
    m_tx_full = 1'b0; m_rx_full = 1'b0; m_ovr = 1'b0; m_udr = 1'b0;
    m_tx_hold = 8'h00; m_rx_hold = 8'h00;
`ifdef WB_SPI_SLAVE_IRQ_EN
    m_irq_en = 2'b00;
`endif
  endfunction

  function automatic logic exp_irq();
`ifdef WB_SPI_SLAVE_IRQ_EN
    return (m_irq_en[0] & m_rx_full) | (m_irq_en[1] & ~m_tx_full);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    string       nm;
    if (wb_ack_o && !wb_we_i) begin
      if (exp_data.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wb_read_unexpected: got 0x%08h with nothing queued", wb_dat_o);
      end else begin
        e  = exp_data.pop_front();
        nm = exp_name.pop_front();
        check(nm, wb_dat_o, e);
      end
    end
  end

  // Master samples MISO on each sck rise (mode 0)
  always @(posedge spi_sck) begin
    logic b;
    if (exp_miso.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL miso_unexpected: got %0b with nothing queued", spi_miso);
    end else begin
      b = exp_miso.pop_front();
      check("miso_bit", {31'b0, spi_miso}, {31'b0, b});
    end
  end

  // ---------------- Wishbone driver ----------------
  task automatic wb_cycle(input logic we, input logic [3:0] idx, input logic [31:0] dat);
    int          n;
    logic [31:0] dummy;
    string       dummy_name;
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = {26'b0, idx, 2'b00}; wb_dat_i = dat; wb_sel_i = 4'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_ack_o && n < 8);
    if (!wb_ack_o) begin
      check("wb_ack_timeout", {31'b0, wb_ack_o}, 32'd1);
      if (!we && exp_data.size() > 0) begin
        dummy      = exp_data.pop_front();
        dummy_name = exp_name.pop_front();
      end
    end
    #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [3:0] idx, input logic [31:0] exp, input string name);
    exp_data.push_back(exp);
    exp_name.push_back(name);
    wb_cycle(1'b0, idx, $urandom);
  endtask

  task automatic cpu_write_tx(input logic [7:0] v);
    logic [31:0] d;
    d = {24'($urandom), v};
    wb_cycle(1'b1, 4'd0, d);
    m_tx_hold = v;
    m_tx_full = 1'b1;
  endtask

  task automatic cpu_read_rx(input string name);
    wb_read(4'd0, {24'b0, m_rx_hold}, name);
    m_rx_full = 1'b0;
  endtask

  task automatic cpu_read_status(input string name);
    wb_read(4'd1, m_status(1'b0), name);
  endtask

  task automatic cpu_w1c(input logic [31:0] d);
    wb_cycle(1'b1, 4'd1, d);
    if (d[4]) m_udr = 1'b0;
    if (d[3]) m_ovr = 1'b0;
  endtask

  task automatic cpu_write_irqen(input logic [31:0] d);
    wb_cycle(1'b1, 4'd2, d);
`ifdef WB_SPI_SLAVE_IRQ_EN
    m_irq_en = d[1:0];
`endif
  endtask

  task automatic cpu_read_irqen(input string name);
`ifdef WB_SPI_SLAVE_IRQ_EN
    wb_read(4'd2, {30'b0, m_irq_en}, name);
`else
    wb_read(4'd2, 32'd0, name);
`endif
  endtask

  task automatic check_idle_pins();
    repeat (2) @(negedge clk);
    check("irq", {31'b0, irq}, {31'b0, exp_irq()});
    check("miso_idle", {31'b0, spi_miso}, 32'd0);
    check("oe_idle", {31'b0, spi_miso_oe}, 32'd0);
  endtask

  // ---------------- SPI master ----------------
  task automatic send_bits(input logic [7:0] mo, input logic [7:0] mi, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = mo[i];
      exp_miso.push_back(mi[i]);
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  // Sends every byte in mosi_bytes with CS held, then tail_bits extra bits
  task automatic spi_frame(input int tail_bits);
    logic [7:0] cur;
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    cur = m_load();
    wb_read(4'd1, m_status(1'b1), "status_in_frame");
    check("oe_in_frame", {31'b0, spi_miso_oe}, 32'd1);
    foreach (mosi_bytes[k]) begin
      send_bits(mosi_bytes[k], cur, 8);
      m_rx_byte(mosi_bytes[k]);
      cur = m_load();
    end
    if (tail_bits > 0) send_bits(8'($urandom), cur, tail_bits);
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
    mosi_bytes.delete();
    check_idle_pins();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] cur;
    int         op, nb;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_dat_o", wb_dat_o, 32'd0);
    check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
    check("rst_miso", {31'b0, spi_miso}, 32'd0);
    check("rst_oe", {31'b0, spi_miso_oe}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    cpu_read_status("rst_status");
    cpu_read_rx("rst_rxdata");

    // 1: TX 0xA5 while master sends 0x3C
    cpu_write_tx(8'hA5);
    mosi_bytes.push_back(8'h3C);
    spi_frame(0);
    cpu_read_status("t1_status_after_frame");
    cpu_w1c(32'h10);
    check("t1_model_status", m_status(1'b0), 32'h02);
    cpu_read_status("t1_status_before_read");
    cpu_read_rx("t1_rxdata");
    cpu_read_status("t1_status_after_read");

    // 2: underrun sends IDLE_BYTE, W1C clears udr
    mosi_bytes.push_back(8'($urandom));
    spi_frame(0);
    cpu_read_status("t2_status_udr");
    cpu_w1c(32'h10);
    cpu_read_status("t2_status_cleared");
    cpu_read_rx("t2_rxdata");

    // 3: two bytes without reading RXDATA -> overrun, second byte kept
    cpu_write_tx(8'($urandom));
    mosi_bytes.push_back(8'($urandom));
    mosi_bytes.push_back(8'($urandom));
    spi_frame(0);
    cpu_read_status("t3_status_ovr");
    cpu_read_rx("t3_rxdata_second");
    cpu_w1c(32'h18);
    cpu_read_status("t3_status_cleared");

    // 4: CS dropped after 5 bits, then a full byte
    cpu_write_tx(8'($urandom));
    spi_frame(5);
    cpu_read_status("t4_status_partial");
    cpu_write_tx(8'($urandom));
    mosi_bytes.push_back(8'($urandom));
    spi_frame(0);
    cpu_read_rx("t4_rxdata");
    cpu_w1c(32'h18);

    // 5: reset in the middle of a frame
    cpu_write_tx(8'($urandom));
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    cur = m_load();
    send_bits(8'($urandom), cur, 4);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_miso", {31'b0, spi_miso}, 32'd0);
    check("t5_oe", {31'b0, spi_miso_oe}, 32'd0);
    check("t5_dat_o", wb_dat_o, 32'd0);
    check("t5_irq", {31'b0, irq}, 32'd0);
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    cpu_read_status("t5_status_after_reset");
    cpu_write_tx(8'($urandom));
    mosi_bytes.push_back(8'($urandom));
    spi_frame(0);
    cpu_read_status("t5_status_clean");
    cpu_read_rx("t5_rxdata_clean");

    // 6: interrupt enable (reads zero and irq stays low without the feature)
    cpu_write_irqen(32'h1);
    cpu_read_irqen("t6_irqen");
    check_idle_pins();
    mosi_bytes.push_back(8'($urandom));
    spi_frame(0);
    check_idle_pins();
    cpu_read_rx("t6_rxdata");
    check_idle_pins();
    cpu_write_irqen(32'h2);
    check_idle_pins();
    cpu_write_tx(8'($urandom));
    check_idle_pins();
    cpu_w1c(32'h18);
    cpu_write_irqen(32'h0);

    // Randomised traffic
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 7);
      case (op)
        0: cpu_write_tx(8'($urandom));
        1: begin
          nb = $urandom_range(0, 3);
          for (int k = 0; k < nb; k++) mosi_bytes.push_back(8'($urandom));
          spi_frame(($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
        end
        2: cpu_read_rx("rnd_rxdata");
        3: cpu_read_status("rnd_status");
        4: cpu_w1c($urandom);
        5: cpu_write_irqen($urandom);
        6: cpu_read_irqen("rnd_irqen");
        default: begin
          wb_cycle(1'b1, 4'($urandom_range(3, 15)), $urandom);
          wb_read(4'($urandom_range(3, 15)), 32'd0, "rnd_unmapped");
        end
      endcase
      check_idle_pins();
    end
    cpu_read_status("final_status");

    repeat (10) @(negedge clk);
    check("rd_queue_drained", 32'(exp_data.size()), 32'd0);
    check("miso_queue_drained", 32'(exp_miso.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
